// File: rtl/ysyx_22040386_imem_resp.sv
// ysyx_22040386_imem_resp
//   Instruction-memory responder. It accepts one fetch request at a time from
//   the fetch unit. After LATENCY cycles it returns the 32-bit instruction at
//   the requested PC, together with that PC and a fault flag.
//
//   Parameters
//     LATENCY    cycles from the request-accept edge to response valid (1..15)
//     PMEM_AW    number of 64-bit words in the instruction image, as log2
//     PMEM_INIT  contents of the instruction image; indexed by addr[3 +: PMEM_AW]
//
//   Ports
//     i_IM_clk         clock, rising edge
//     i_IM_rst_n       asynchronous active-low reset
//     i_IM_req_valid   fetch request valid
//     i_IM_req_addr    fetch PC (64)
//     o_IM_req_ready   request can be accepted this cycle
//     i_IM_flush       branch redirect, cancels any outstanding fetch
//     o_IM_resp_valid  response valid
//     i_IM_resp_ready  fetch unit takes the response
//     o_IM_resp_inst   fetched instruction (32)
//     o_IM_resp_pc     PC of the returned instruction (64)
//     o_IM_resp_err    fetch fault (misaligned PC)
//
//   Build option
//     YSYX_22040386_IMEM_ALIGN_CHECK_EN
//       When defined, a PC with addr[1:0] != 0 returns err=1 and inst=0, and
//       the memory is not read. When undefined, addr[1:0] is ignored and err
//       is always 0.
//
//   pmem_read is a 64-bit read of a read-only image held in PMEM_INIT. It
//   stands in for the simulator-side memory so the block stays synthesizable.
//   Addresses outside the image window alias onto it.

module ysyx_22040386_imem_resp #(
  parameter int          LATENCY   = 1,
  parameter int          PMEM_AW   = 4,
  parameter logic [63:0] PMEM_INIT [2**PMEM_AW] = '{default: 64'h0}
) (
  input  logic        i_IM_clk,
  input  logic        i_IM_rst_n,
  input  logic        i_IM_req_valid,
  input  logic [63:0] i_IM_req_addr,
  output logic        o_IM_req_ready,
  input  logic        i_IM_flush,
  output logic        o_IM_resp_valid,
  input  logic        i_IM_resp_ready,
  output logic [31:0] o_IM_resp_inst,
  output logic [63:0] o_IM_resp_pc,
  output logic        o_IM_resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter runs 0..LATENCY-2 while in WAIT.
  // The final WAIT cycle therefore hands over to RESP.
  localparam logic [3:0] WAIT_LAST = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] addr_q;
  logic        accept;
  logic        handshake;
  logic        enter_resp;
  logic [63:0] fetch_addr;
  logic        fetch_misaligned;
  logic [63:0] fetch_data;
  logic [31:0] fetch_inst;

  function automatic logic [63:0] pmem_read(input logic [PMEM_AW-1:0] idx);
    return PMEM_INIT[idx];
  endfunction

  // Ready is withheld during reset and during a flush. Otherwise it is given
  // when idle, or when the current response is being taken this cycle.
  // Holding back while in WAIT keeps at most one fetch outstanding.
  always_comb begin
    o_IM_req_ready  = i_IM_rst_n && !i_IM_flush &&
                      ((state == IDLE) || ((state == RESP) && i_IM_resp_ready));
    accept          = i_IM_req_valid && o_IM_req_ready;
    handshake       = (state == RESP) && i_IM_resp_ready;
    o_IM_resp_valid = (state == RESP);
  end

  // Next-state logic.
  // A flush always wins: it retires a pending response and blocks any new
  // accept, because ready is already low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
          cnt_nxt   = 4'd0;
        end
      end
      WAIT: begin
        if (i_IM_flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == WAIT_LAST) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        if (i_IM_flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (handshake) begin
          if (accept) begin
            state_nxt = (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state_nxt = IDLE;
          end
          cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The response registers load only when RESP is entered.
  // This covers two cases: arriving from IDLE or WAIT, and a back-to-back
  // request in the handshake cycle when LATENCY is 1.
  // If the accept happens on this same edge, the address comes straight
  // from the request port, because addr_q has not been updated yet.
  always_comb begin
    enter_resp = (state_nxt == RESP) && ((state != RESP) || accept);
    fetch_addr = accept ? i_IM_req_addr : addr_q;
`ifdef YSYX_22040386_IMEM_ALIGN_CHECK_EN
    fetch_misaligned = |fetch_addr[1:0];
`else
    fetch_misaligned = 1'b0;
`endif
    fetch_data = 64'h0;
    fetch_inst = 32'h0;
    if (!fetch_misaligned) begin
      fetch_data = pmem_read(fetch_addr[3 +: PMEM_AW]);
      fetch_inst = fetch_addr[2] ? fetch_data[63:32] : fetch_data[31:0];
    end
  end

  always_ff @(posedge i_IM_clk or negedge i_IM_rst_n) begin
    if (!i_IM_rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      addr_q         <= 64'h0;
      o_IM_resp_inst <= 32'h0;
      o_IM_resp_pc   <= 64'h0;
      o_IM_resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= i_IM_req_addr;
      end
      if (enter_resp) begin
        o_IM_resp_inst <= fetch_inst;
        o_IM_resp_pc   <= fetch_addr;
        o_IM_resp_err  <= fetch_misaligned;
      end
    end
  end

endmodule

// File: doc/ysyx_22040386_imem_resp.md
YSYX_22040386_IMEM_RESP -- requirements
Module: ysyx_22040386_imem_resp

Interface
REQ-001 Parameter LATENCY, default 1, meaning request-accept to response-valid delay in cycles; legal range 1..15.
REQ-002 i_IM_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_IM_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_IM_req_valid  input  1  fetch request valid from the fetch unit.
REQ-005 i_IM_req_addr  input  64  fetch PC.
REQ-006 o_IM_req_ready  output  1  responder can accept a request this cycle.
REQ-007 i_IM_flush  input  1  branch redirect; cancels any outstanding fetch.
REQ-008 o_IM_resp_valid  output  1  response valid.
REQ-009 i_IM_resp_ready  input  1  fetch unit accepts the response.
REQ-010 o_IM_resp_inst  output  32  fetched instruction.
REQ-011 o_IM_resp_pc  output  64  PC of the returned instruction.
REQ-012 o_IM_resp_err  output  1  fetch fault (misaligned PC).

Function
REQ-013 The block SHALL implement states IDLE, WAIT and RESP, held in a registered state variable.
REQ-014 o_IM_req_ready SHALL equal !i_IM_flush && (IDLE || (RESP && i_IM_resp_ready)); at most one request is outstanding.
REQ-015 A request SHALL be accepted on a rising edge where i_IM_req_valid && o_IM_req_ready; the block latches i_IM_req_addr at that edge.
REQ-016 On accept: LATENCY==1 -> RESP next cycle; LATENCY>1 -> WAIT with a 4-bit counter cleared to 0.
REQ-017 In WAIT the counter SHALL increment each cycle; when it reaches LATENCY-2, the next state is RESP. o_IM_resp_valid therefore rises exactly LATENCY cycles after the accept edge.
REQ-018 On entry to RESP the block SHALL read 64 bits via DPI pmem_read at {addr[63:3],3'b000} and register the result. o_IM_resp_inst SHALL be data[63:32] when addr[2]=1, else data[31:0].
REQ-019 In RESP: o_IM_resp_valid=1; o_IM_resp_inst, o_IM_resp_pc and o_IM_resp_err SHALL hold stable until i_IM_resp_ready=1.
REQ-020 On RESP handshake: with a new request accepted in the same cycle, the next state follows REQ-016; otherwise the next state is IDLE.
REQ-021 i_IM_flush=1 in WAIT or RESP SHALL force IDLE at the next edge, drop the pending response and leave the counter at 0. A flush coinciding with a RESP handshake counts as a completed handshake, and no new request is accepted in that cycle.
REQ-022 In IDLE and WAIT, o_IM_resp_valid SHALL be 0 and the response data outputs SHALL retain their last values.
REQ-023 Requests presented while o_IM_req_ready=0 SHALL be ignored and not queued.

Reset
REQ-024 While i_IM_rst_n=0 the block SHALL asynchronously force state=IDLE, counter=0, o_IM_resp_valid=0, o_IM_resp_inst=32'h0, o_IM_resp_pc=64'h0 and o_IM_resp_err=0. o_IM_req_ready SHALL be 0 during reset.
REQ-025 Reset asserted mid-WAIT or mid-RESP SHALL abandon the transaction; no response is issued after reset release.
REQ-026 The first request SHALL be accepted in the first cycle after i_IM_rst_n deasserts.

Configuration
REQ-027 Macro YSYX_22040386_IMEM_ALIGN_CHECK_EN: when defined, a request with addr[1:0]!=0 SHALL return o_IM_resp_err=1 and o_IM_resp_inst=32'h0 with the same latency, and no pmem_read is issued. When undefined, addr[1:0] SHALL be ignored, o_IM_resp_err SHALL be tied to 0, and the read proceeds normally.

Verification
REQ-028 LATENCY=1; mem[0x80000000]=64'h00100093_00000513; request 0x80000000 -> resp_valid next cycle, inst=32'h00000513, pc=0x80000000.
REQ-029 LATENCY=3; request 0x80000004 with resp_ready=1 -> resp_valid exactly 3 cycles after accept, inst=32'h00100093; back-to-back request 0x80000008 accepted in the handshake cycle.
REQ-030 LATENCY=2; resp_ready held 0 for 5 cycles -> resp_valid, inst and pc stable all 5 cycles; req_ready=0 throughout.
REQ-031 LATENCY=4; flush 2 cycles after accept -> no resp_valid; next request 0x80000010 returns correctly after 4 cycles.
REQ-032 ALIGN_CHECK_EN defined, request 0x80000002 -> resp_err=1, inst=0; macro undefined -> resp_err=0, inst=mem word at 0x80000000.
REQ-033 Reset pulse in RESP -> resp_valid=0 immediately (asynchronous); req_ready=1 in the first cycle after release.
